// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the multi-cycle 16-bit SRAM data-memory controller.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned SRAM_WAIT_DEF = 2;
    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned SRAM_AW       = 18;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned HALF_W        = 16;
    localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage request/response bundle between the pipeline and the SRAM controller.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit data access into two timed 16-bit accesses on an asynchronous SRAM.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF,
    parameter int unsigned SRAM_AW   = sram_controller_pkg::SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [HALF_W-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               op_rd, op_rd_nxt;
    logic [DATA_W-1:0]  read_data_q;
    logic [DATA_W-1:0]  off;
    logic               req;
    logic               last;
    logic               half;
    logic               dq_oe;
    logic [HALF_W-1:0]  dq_out;
    logic               unused_off;

    assign req  = bus.rd_en | bus.wr_en;
    assign last = (cnt == CNT_LAST);

    // Byte offset from the data base; bits [1:0] and above the SRAM span are dropped.
    assign off        = bus.address - DATA_W'(BASE_ADDR);
    assign unused_off = ^{off[DATA_W-1:SRAM_AW+1], off[1:0]};

    // State register: FSM state, phase counter and latched operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_rd <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_rd <= op_rd_nxt;
        end
    end

    // Load data capture: low half on LO exit, high half on HI exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q <= '0;
        end else if (op_rd && last) begin
            if (state == LO) read_data_q[HALF_W-1:0]      <= SRAM_DQ;
            if (state == HI) read_data_q[DATA_W-1:HALF_W] <= SRAM_DQ;
        end
    end

    // Next-state logic: each half access lasts SRAM_WAIT cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_rd_nxt = op_rd;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LO;
                    cnt_nxt   = '0;
                    op_rd_nxt = bus.rd_en;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HI: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: strobes, address and data drive from the current state.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        half      = (state == HI);
        bus.ready = (state == DONE) || ((state == IDLE) && !req);
        if ((state == LO) || (state == HI)) begin
            SRAM_ADDR = {off[SRAM_AW:2], half};
            SRAM_CE_N = 1'b0;
            SRAM_OE_N = !op_rd;
            // Last cycle of each phase releases WE_N so the address never moves under it.
            SRAM_WE_N = op_rd || (cnt >= CNT_LAST);
            dq_oe     = !op_rd;
            dq_out    = half ? bus.write_data[DATA_W-1:HALF_W] : bus.write_data[HALF_W-1:0];
        end
    end

    assign SRAM_DQ       = dq_oe ? dq_out : {HALF_W{1'bz}};
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural asynchronous SRAM model.
module sram_model #(
    parameter int unsigned AW = 18
) (
    input  logic          clk,
    inout  wire  [15:0]   dq,
    input  logic [AW-1:0] addr,
    input  logic          we_n,
    input  logic          oe_n,
    input  logic          ce_n,
    input  logic          ub_n,
    input  logic          lb_n
);
    logic [15:0] mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    end

    assign dq = (!ce_n && !oe_n && we_n && !(ub_n && lb_n)) ? mem[addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[addr][7:0]  <= dq[7:0];
            if (!ub_n) mem[addr][15:8] <= dq[15:8];
        end
    end
endmodule

module tb_sram_controller;

    localparam int unsigned AW = 18;

    logic clk;
    logic rst;
    logic sel;
    int   checks;
    int   errors;
    int   we_low;

    sram_controller_if if0();
    sram_controller_if if1();

    tri1  [15:0]   dq0, dq1;
    logic [AW-1:0] addr0, addr1;
    logic          we0, oe0, ce0, ub0, lb0;
    logic          we1, oe1, ce1, ub1, lb1;

    sram_controller #(.SRAM_WAIT(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .SRAM_DQ(dq0), .SRAM_ADDR(addr0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );
    sram_model #(.AW(AW)) u_sram0 (
        .clk(clk), .dq(dq0), .addr(addr0), .we_n(we0), .oe_n(oe0), .ce_n(ce0), .ub_n(ub0), .lb_n(lb0)
    );

    sram_controller #(.SRAM_WAIT(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .SRAM_DQ(dq1), .SRAM_ADDR(addr1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );
    sram_model #(.AW(AW)) u_sram1 (
        .clk(clk), .dq(dq1), .addr(addr1), .we_n(we1), .oe_n(oe1), .ce_n(ce1), .ub_n(ub1), .lb_n(lb1)
    );

    wire          obs_ready = sel ? if1.ready     : if0.ready;
    wire [31:0]   obs_rdata = sel ? if1.read_data : if0.read_data;
    wire [15:0]   obs_dq    = sel ? dq1   : dq0;
    wire [AW-1:0] obs_addr  = sel ? addr1 : addr0;
    wire          obs_we_n  = sel ? we1   : we0;
    wire          obs_oe_n  = sel ? oe1   : oe0;
    wire          obs_ce_n  = sel ? ce1   : ce0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit s, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
        if (!s) begin
            if0.rd_en = rd; if0.wr_en = wr; if0.address = a; if0.write_data = wd;
        end else begin
            if1.rd_en = rd; if1.wr_en = wr; if1.address = a; if1.write_data = wd;
        end
    endtask

    // One complete access starting in IDLE; checks every cycle up to and including DONE.
    task automatic access(input bit s, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        int unsigned w;
        int unsigned cnt;
        logic [31:0] off;
        logic        half;
        w   = s ? 4 : 2;
        off = a - 32'd1024;
        @(negedge clk);
        sel = s;
        drive(s, rd, wr, a, wd);
        #1;
        chk("req_ready", 32'(obs_ready), 32'd0);
        we_low = 0;
        for (int c = 1; c <= 2 * int'(w) + 1; c++) begin
            @(negedge clk);
            if (c <= 2 * int'(w)) begin
                half = (c > int'(w));
                cnt  = half ? c - w - 1 : c - 1;
                chk("ready_busy", 32'(obs_ready), 32'd0);
                chk("ce_n", 32'(obs_ce_n), 32'd0);
                chk("oe_n", 32'(obs_oe_n), rd ? 32'd0 : 32'd1);
                chk("we_n", 32'(obs_we_n), (!rd && cnt < w - 1) ? 32'd0 : 32'd1);
                chk("sram_addr", 32'(obs_addr), 32'({off[18:2], half}));
                if (!rd) chk("dq_drive", 32'(obs_dq), half ? 32'(wd[31:16]) : 32'(wd[15:0]));
                if (!obs_we_n) we_low++;
            end else begin
                chk("ready_done", 32'(obs_ready), 32'd1);
                chk("ce_n_done", 32'(obs_ce_n), 32'd1);
                chk("addr_done", 32'(obs_addr), 32'd0);
                if (rd) chk("read_data", obs_rdata, exp_rd);
                drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(obs_ready), 32'd1);
        chk("rst_rdata", obs_rdata, 32'd0);
        chk("rst_ce_n", 32'(obs_ce_n), 32'd1);
        chk("rst_we_n", 32'(obs_we_n), 32'd1);
        chk("rst_oe_n", 32'(obs_oe_n), 32'd1);
        chk("rst_addr", 32'(obs_addr), 32'd0);
        chk("rst_dq", 32'(obs_dq), 32'h0000ffff);
        rst = 1'b1;

        // Write then read at the base address.
        access(1'b0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd0);
        chk("mem0_w0", 32'(u_sram0.mem[0]), 32'h0000BEEF);
        chk("mem0_w1", 32'(u_sram0.mem[1]), 32'h0000DEAD);
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF);

        // Address mapping, ignored low bits, and read_data untouched by writes.
        access(1'b0, 1'b0, 1'b1, 32'd1032, 32'h12345678, 32'd0);
        chk("mem0_w4", 32'(u_sram0.mem[4]), 32'h00005678);
        chk("mem0_w5", 32'(u_sram0.mem[5]), 32'h00001234);
        chk("rd_hold", obs_rdata, 32'hDEADBEEF);
        access(1'b0, 1'b1, 1'b0, 32'd1035, 32'd0, 32'h12345678);

        // Read wins when both requests are high.
        access(1'b0, 1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 32'hDEADBEEF);
        chk("prio_w0", 32'(u_sram0.mem[0]), 32'h0000BEEF);
        chk("prio_w1", 32'(u_sram0.mem[1]), 32'h0000DEAD);

        // Back-to-back reads held continuously.
        @(negedge clk);
        sel = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
        #1 chk("b2b_ready_c0", 32'(obs_ready), 32'd0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", c), 32'(obs_ready), (c == 5 || c == 11) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("b2b_rdata", obs_rdata, 32'hDEADBEEF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_ready", 32'(obs_ready), 32'd1);
        end

        // Reset asserted during the LO phase of a write.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'h55AA33CC);
        @(negedge clk);
        chk("pre_rst_we_n", 32'(obs_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(obs_we_n), 32'd1);
        chk("mid_rst_ce_n", 32'(obs_ce_n), 32'd1);
        chk("mid_rst_dq", 32'(obs_dq), 32'h0000ffff);
        chk("mid_rst_rdata", obs_rdata, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(obs_ready), 32'd1);
        chk("post_rst_addr", 32'(obs_addr), 32'd0);
        chk("aborted_write", 32'(u_sram0.mem[8]), 32'd0);

        // Four-cycle half accesses.
        access(1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 32'd0);
        chk("w4_we_low", 32'(we_low), 32'd6);
        chk("mem1_w0", 32'(u_sram1.mem[0]), 32'h0000F00D);
        chk("mem1_w1", 32'(u_sram1.mem[1]), 32'h0000CAFE);
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 32'hCAFEF00D);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle controller between the memory stage and a 16-bit asynchronous off-chip SRAM. It replaces the single-cycle data memory.
- Splits each 32-bit word access into two 16-bit half accesses, each lasting SRAM_WAIT cycles.
- Reports completion through ready. The top level freezes the pipeline while a request is pending and ready is low.

Parameters:
- BASE_ADDR, 1024, byte address of the first data word; it maps to SRAM word 0.
- SRAM_WAIT, 2, cycles per 16-bit half access; legal range 2..15.
- SRAM_AW, 18, SRAM address width in 16-bit words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  store request from the memory stage
- rd_en  in  1  load request from the memory stage; has priority if both are high
- address  in  32  byte address, equal to the ALU result
- write_data  in  32  store data, equal to Val_Rm
- read_data  out  32  registered load data
- ready  out  1  request complete, or no request present
- SRAM_DQ  inout  16  bidirectional data bus
- SRAM_ADDR  out  SRAM_AW  half-word address
- SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes

Behaviour:
- States: IDLE, LO, HI, DONE. There is a 4-bit phase counter cnt.
- Reset (rst=0, asynchronous, may occur mid-access), all applied immediately:
  - state=IDLE, cnt=0, read_data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_CE_N=1, SRAM_DQ=Z.
- IDLE:
  - If rd_en or wr_en: go to LO with cnt=0; op latched as read if rd_en, else write.
  - Otherwise stay in IDLE.
- LO:
  - cnt increments each cycle.
  - When cnt==SRAM_WAIT-1: go to HI with cnt=0. On a read, also capture read_data[15:0] from SRAM_DQ on that edge.
- HI:
  - Same counting as LO. On exit, capture read_data[31:16] (read only) and go to DONE.
- DONE: lasts one cycle, then go to IDLE unconditionally.
- ready (combinational) = (state==DONE) OR (state==IDLE AND NOT rd_en AND NOT wr_en).
- Latency: a request first seen in IDLE at cycle 0 gets ready=1 in cycle 2*SRAM_WAIT+1, i.e. cycle 5 at the default. The pipeline advances on that edge.
- Back-to-back: a request present in the cycle after DONE is a new access and restarts from IDLE. There is no request coalescing.
- Address mapping:
  - off = address - BASE_ADDR, 32-bit modulo.
  - word = off[SRAM_AW:2]; address bits [1:0] are ignored.
  - SRAM_ADDR = {word[SRAM_AW-2:0], half}, with half=0 in LO and 1 in HI.
  - SRAM_ADDR = 0 in IDLE and DONE.
  - Out-of-range addresses wrap silently.
- Strobes:
  - SRAM_CE_N=0 in LO/HI, else 1.
  - SRAM_UB_N and SRAM_LB_N are held at 0.
  - SRAM_OE_N=0 in LO/HI for reads, else 1.
  - Writes: SRAM_WE_N=0 in LO/HI while cnt<SRAM_WAIT-1, else 1. The last cycle of each phase is write recovery, so the address never changes with WE_N low.
  - SRAM_DQ is driven only for writes in LO/HI: write_data[15:0] in LO, write_data[31:16] in HI. Otherwise it is Z.
- read_data holds its value until the next read completes. Writes do not alter it.
- Request inputs change only after ready; any change mid-access is ignored because op is latched.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, LO, HI, DONE}
  - the SRAM_WAIT and BASE_ADDR defaults
  - the SRAM_AW and DATA_W=32 constants
- RTL has no sub-module; the FSM, counter and address mapping form one block.
- The bench uses a separate behavioural sram_model: 2^SRAM_AW x 16 storage that honours the strobes.

Test Plan:
- Reset: hold rst=0 mid-LO of a write -> WE_N=1, DQ=Z and read_data=0 the same cycle; after release, state IDLE and ready=1.
- Write, then read: write address=1024, data=0xDEADBEEF -> SRAM word 0 = 0xBEEF and word 1 = 0xDEAD; ready high only in cycle 5. Read of 1024 -> read_data=0xDEADBEEF in cycle 5.
- Mapping: write address=1032, data=0x12345678 -> SRAM_ADDR 4 (LO) and 5 (HI). Address 1035 maps the same as 1032.
- Priority: rd_en=wr_en=1 at address 1024 -> read performed, SRAM contents unchanged, OE_N=0 and WE_N=1 throughout.
- Back-to-back: two reads held continuously -> ready pulses at cycles 5 and 11; idle (no request) -> ready constantly 1.
- Parameter: SRAM_WAIT=4 -> ready at cycle 9; WE_N low for 3 of every 4 phase cycles.
